dna_stream_feeder: RTL and testbench

- Transmit side of the comparison-array character interface: accepts an ASCII nucleotide byte stream from the host and drives the first array cell.
- Decodes ASCII to 3-bit nucleotide codes.
- Loads the query first (query_enable strobes), then streams the subject (sub_enable strobes), then flushes the systolic chain with non-matching fill characters.
- Sits between the host-side byte buffer and the array head.

---
 rtl/dna_stream_feeder_pkg.sv | 48 ++++
 rtl/dna_stream_feeder_ascii_nuc_decode.sv | 24 ++
 rtl/dna_stream_feeder.sv | 229 ++++++++++++++++++++++
 tb/tb_dna_stream_feeder.sv | 277 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/dna_stream_feeder_pkg.sv
// Shared definitions for the DNA stream feeder: nucleotide codes,
// FSM state encoding and the decoded-character record.
package dna_stream_feeder_pkg;

  // Width of a nucleotide code on the array interface.
  localparam int NUC_W = 3;

  // Nucleotide codes. 'N' maps onto the fill code so that it never matches.
  localparam logic [NUC_W-1:0] NUC_FILL = 3'b000;
  localparam logic [NUC_W-1:0] NUC_A    = 3'b001;
  localparam logic [NUC_W-1:0] NUC_G    = 3'b010;
  localparam logic [NUC_W-1:0] NUC_T    = 3'b011;
  localparam logic [NUC_W-1:0] NUC_C    = 3'b100;
  localparam logic [NUC_W-1:0] NUC_N    = NUC_FILL;

  // Feeder states.
  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_QUERY  = 3'd1,
    ST_SUB    = 3'd2,
    ST_FLUSH  = 3'd3,
    ST_FINISH = 3'd4
  } state_e;

  // Classification of one host byte.
  typedef struct packed {
    logic [NUC_W-1:0] code;
    logic             is_base;
    logic             is_n;
    logic             is_other;
  } nuc_dec_t;

  // ASCII byte -> decoded nucleotide record (case-insensitive).
  function automatic nuc_dec_t ascii_to_nuc(input logic [7:0] b);
    nuc_dec_t r;
    r = '{code: NUC_FILL, is_base: 1'b0, is_n: 1'b0, is_other: 1'b1};
    case (b)
      8'h41, 8'h61: r = '{code: NUC_A, is_base: 1'b1, is_n: 1'b0, is_other: 1'b0};
      8'h47, 8'h67: r = '{code: NUC_G, is_base: 1'b1, is_n: 1'b0, is_other: 1'b0};
      8'h54, 8'h74: r = '{code: NUC_T, is_base: 1'b1, is_n: 1'b0, is_other: 1'b0};
      8'h43, 8'h63: r = '{code: NUC_C, is_base: 1'b1, is_n: 1'b0, is_other: 1'b0};
      8'h4E, 8'h6E: r = '{code: NUC_N, is_base: 1'b0, is_n: 1'b1, is_other: 1'b0};
      default:      r = '{code: NUC_FILL, is_base: 1'b0, is_n: 1'b0, is_other: 1'b1};
    endcase
    return r;
  endfunction

endpackage

// File: rtl/dna_stream_feeder_ascii_nuc_decode.sv
// Combinational ASCII -> nucleotide decoder. Kept as its own block so a
// host-side decoder can reuse exactly the same classification.
module dna_stream_feeder_ascii_nuc_decode
  import dna_stream_feeder_pkg::*;
(
  input  logic [7:0]       byte_i,
  output logic [NUC_W-1:0] code_o,
  output logic             is_base_o,
  output logic             is_n_o,
  output logic             is_other_o
);

  nuc_dec_t dec;

  // Classify the incoming byte.
  always_comb begin
    dec        = ascii_to_nuc(byte_i);
    code_o     = dec.code;
    is_base_o  = dec.is_base;
    is_n_o     = dec.is_n;
    is_other_o = dec.is_other;
  end

endmodule

// File: rtl/dna_stream_feeder.sv
// Feeds the head of the comparison array: loads the query, streams the
// subject, then flushes the systolic chain with fill characters.
module dna_stream_feeder
  import dna_stream_feeder_pkg::*;
#(
  parameter int LENGTH_CHAR    = 3,
  parameter int LENGTH_COUNTER = 8,
  parameter int LENGTH_ADDRESS = 16,
  parameter int FLUSH_CYCLES   = 6
) (
  input  logic                      com_clk,
  input  logic                      reset,
  input  logic                      start,
  input  logic [LENGTH_ADDRESS-1:0] query_len,
  input  logic [LENGTH_ADDRESS-1:0] sub_len,
  input  logic [7:0]                in_data,
  input  logic                      in_valid,
  output logic                      in_ready,
  output logic [LENGTH_CHAR-1:0]    query_char_out,
  output logic                      query_enable,
  output logic [LENGTH_CHAR-1:0]    sub_char_out,
  output logic                      sub_enable,
  output logic                      busy,
  output logic                      done,
  output logic                      err,
  output logic [LENGTH_COUNTER-1:0] dropped_count
);

  localparam int FLUSH_W = (FLUSH_CYCLES < 2) ? 1 : $clog2(FLUSH_CYCLES);

  state_e state_q, state_d;

  logic [LENGTH_ADDRESS-1:0] q_len_q, q_len_d;
  logic [LENGTH_ADDRESS-1:0] s_len_q, s_len_d;
  logic [LENGTH_ADDRESS-1:0] q_pos_q, q_pos_d;
  logic [LENGTH_ADDRESS-1:0] s_pos_q, s_pos_d;
  logic [FLUSH_W-1:0]        flush_cnt_q, flush_cnt_d;
  logic [LENGTH_CHAR-1:0]    q_char_q, q_char_d;
  logic                      q_en_q, q_en_d;
  logic [LENGTH_CHAR-1:0]    s_char_q, s_char_d;
  logic                      s_en_q, s_en_d;
  logic                      done_q, done_d;
  logic                      err_q, err_d;
  logic [LENGTH_COUNTER-1:0] drop_q, drop_d;

  logic [NUC_W-1:0] dec_code;
  logic             dec_is_base;
  logic             dec_is_n;
  logic             dec_is_other;

  logic ready_c;
  logic accept;
  logic q_last;
  logic s_last;
  logic flush_last;

  dna_stream_feeder_ascii_nuc_decode u_decode (
    .byte_i     (in_data),
    .code_o     (dec_code),
    .is_base_o  (dec_is_base),
    .is_n_o     (dec_is_n),
    .is_other_o (dec_is_other)
  );

  assign accept     = in_valid && ready_c;
  assign q_last     = (q_pos_q == q_len_q - LENGTH_ADDRESS'(1));
  assign s_last     = (s_pos_q == s_len_q - LENGTH_ADDRESS'(1));
  assign flush_last = (flush_cnt_q == FLUSH_W'(FLUSH_CYCLES - 1));

  // State register.
  always_ff @(posedge com_clk) begin
    if (reset) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic; 'N' in the query aborts, the last character of each
  // phase hands over without a bubble.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          state_d = (query_len == '0) ? ST_FINISH : ST_QUERY;
        end
      end
      ST_QUERY: begin
        if (accept) begin
          if (dec_is_n) begin
            state_d = ST_FINISH;
          end else if (dec_is_base && q_last) begin
            state_d = (s_len_q == '0) ? ST_FLUSH : ST_SUB;
          end
        end
      end
      ST_SUB: begin
        if (accept && (dec_is_base || dec_is_n) && s_last) begin
          state_d = ST_FLUSH;
        end
      end
      ST_FLUSH: begin
        if (flush_last) begin
          state_d = ST_FINISH;
        end
      end
      ST_FINISH: state_d = ST_IDLE;
      default:   state_d = ST_IDLE;
    endcase
  end

  // Combinational outputs: handshake readiness and busy follow the state.
  always_comb begin
    ready_c = 1'b0;
    busy    = 1'b0;
    case (state_q)
      ST_IDLE:  begin ready_c = 1'b0; busy = 1'b0; end
      ST_QUERY: begin ready_c = 1'b1; busy = 1'b1; end
      ST_SUB:   begin ready_c = 1'b1; busy = 1'b1; end
      default:  begin ready_c = 1'b0; busy = 1'b1; end
    endcase
  end

  assign in_ready = ready_c;

  // Datapath next values: strobes are registered so they appear one cycle
  // after acceptance; character outputs hold when their strobe is low.
  always_comb begin
    q_len_d     = q_len_q;
    s_len_d     = s_len_q;
    q_pos_d     = q_pos_q;
    s_pos_d     = s_pos_q;
    flush_cnt_d = flush_cnt_q;
    q_char_d    = q_char_q;
    q_en_d      = 1'b0;
    s_char_d    = s_char_q;
    s_en_d      = 1'b0;
    done_d      = (state_q == ST_FINISH);
    err_d       = err_q;
    drop_d      = drop_q;

    case (state_q)
      ST_IDLE: begin
        if (start) begin
          q_len_d     = query_len;
          s_len_d     = sub_len;
          q_pos_d     = '0;
          s_pos_d     = '0;
          flush_cnt_d = '0;
          drop_d      = '0;
          err_d       = (query_len == '0);
        end
      end
      ST_QUERY: begin
        if (accept) begin
          if (dec_is_base) begin
            q_char_d = LENGTH_CHAR'(dec_code);
            q_en_d   = 1'b1;
            q_pos_d  = q_pos_q + LENGTH_ADDRESS'(1);
          end else if (dec_is_n) begin
            err_d = 1'b1;
          end else if (dec_is_other && (drop_q != {LENGTH_COUNTER{1'b1}})) begin
            drop_d = drop_q + LENGTH_COUNTER'(1);
          end
        end
      end
      ST_SUB: begin
        if (accept) begin
          if (dec_is_base || dec_is_n) begin
            // 'N' decodes to the fill code, so it keeps its slot but never matches.
            s_char_d = LENGTH_CHAR'(dec_code);
            s_en_d   = 1'b1;
            s_pos_d  = s_pos_q + LENGTH_ADDRESS'(1);
          end else if (dec_is_other && (drop_q != {LENGTH_COUNTER{1'b1}})) begin
            drop_d = drop_q + LENGTH_COUNTER'(1);
          end
        end
      end
      ST_FLUSH: begin
        s_char_d    = LENGTH_CHAR'(NUC_FILL);
        s_en_d      = 1'b1;
        flush_cnt_d = flush_cnt_q + FLUSH_W'(1);
      end
      default: begin
      end
    endcase
  end

  // Datapath registers; reset clears every output and counter.
  always_ff @(posedge com_clk) begin
    if (reset) begin
      q_len_q     <= '0;
      s_len_q     <= '0;
      q_pos_q     <= '0;
      s_pos_q     <= '0;
      flush_cnt_q <= '0;
      q_char_q    <= '0;
      q_en_q      <= 1'b0;
      s_char_q    <= '0;
      s_en_q      <= 1'b0;
      done_q      <= 1'b0;
      err_q       <= 1'b0;
      drop_q      <= '0;
    end else begin
      q_len_q     <= q_len_d;
      s_len_q     <= s_len_d;
      q_pos_q     <= q_pos_d;
      s_pos_q     <= s_pos_d;
      flush_cnt_q <= flush_cnt_d;
      q_char_q    <= q_char_d;
      q_en_q      <= q_en_d;
      s_char_q    <= s_char_d;
      s_en_q      <= s_en_d;
      done_q      <= done_d;
      err_q       <= err_d;
      drop_q      <= drop_d;
    end
  end

  assign query_char_out = q_char_q;
  assign query_enable   = q_en_q;
  assign sub_char_out   = s_char_q;
  assign sub_enable     = s_en_q;
  assign done           = done_q;
  assign err            = err_q;
  assign dropped_count  = drop_q;

endmodule

// File: tb/tb_dna_stream_feeder.sv
// Self-checking bench for dna_stream_feeder: table of runs plus hand-written
// sequences for zero-length query and reset in the middle of a run.
module tb_dna_stream_feeder;

  logic        com_clk = 1'b0;
  logic        reset;
  logic        start;
  logic [15:0] query_len;
  logic [15:0] sub_len;
  logic [7:0]  in_data;
  logic        in_valid;
  logic        in_ready;
  logic [2:0]  query_char_out;
  logic        query_enable;
  logic [2:0]  sub_char_out;
  logic        sub_enable;
  logic        busy;
  logic        done;
  logic        err;
  logic [7:0]  dropped_count;

  always #5 com_clk = ~com_clk;

  dna_stream_feeder #(
    .LENGTH_CHAR    (3),
    .LENGTH_COUNTER (8),
    .LENGTH_ADDRESS (16),
    .FLUSH_CYCLES   (6)
  ) dut (
    .com_clk        (com_clk),
    .reset          (reset),
    .start          (start),
    .query_len      (query_len),
    .sub_len        (sub_len),
    .in_data        (in_data),
    .in_valid       (in_valid),
    .in_ready       (in_ready),
    .query_char_out (query_char_out),
    .query_enable   (query_enable),
    .sub_char_out   (sub_char_out),
    .sub_enable     (sub_enable),
    .busy           (busy),
    .done           (done),
    .err            (err),
    .dropped_count  (dropped_count)
  );

  // One expected strobe: which port, and the code it must carry.
  typedef struct packed {
    logic       is_sub;
    logic [2:0] code;
  } ev_t;

  // One table run: lengths, host bytes, expected query/sub codes as digit
  // strings (sub string includes the six trailing fill codes), drops, err,
  // and whether the strobes must run without gaps from query into sub.
  typedef struct {
    int    qlen;
    int    slen;
    string bytes;
    string exp_q;
    string exp_s;
    int    exp_drop;
    int    exp_err;
    bit    contig;
  } vec_t;

  ev_t  sb[$];
  vec_t vecs[6];

  int n_compared = 0;
  int n_failed   = 0;
  int cyc        = 0;

  int last_q_cyc, first_s_cyc, last_s_cyc, s_cnt, done_cyc, done_cnt;
  bit ready_seen;

  always @(posedge com_clk) cyc++;

  task automatic check(input string name, input longint act, input longint exp);
    n_compared++;
    if (act != exp) begin
      n_failed++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic pop_compare(input string name, input ev_t got);
    ev_t e;
    if (sb.size() == 0) begin
      n_compared++;
      n_failed++;
      $display("FAIL %s: unexpected strobe code %0d at cycle %0d, expected none", name, got.code, cyc);
    end else begin
      e = sb.pop_front();
      check(name, longint'(got), longint'(e));
    end
  endtask

  // Strobe monitor, sampling on the falling edge.
  always @(negedge com_clk) begin
    if (reset !== 1'b1) begin
      if (in_ready) ready_seen = 1'b1;
      if (done) begin
        done_cnt++;
        done_cyc = cyc;
      end
      if (query_enable && sub_enable) check("enable_exclusive", 1, 0);
      if (query_enable) begin
        last_q_cyc = cyc;
        pop_compare("query_strobe", {1'b0, query_char_out});
      end
      if (sub_enable) begin
        if (s_cnt == 0) first_s_cyc = cyc;
        last_s_cyc = cyc;
        s_cnt++;
        pop_compare("sub_strobe", {1'b1, sub_char_out});
      end
    end
  end

  function automatic vec_t mk(input int ql, input int sl, input string b, input string eq,
                              input string es, input int ed, input int ee, input bit ct);
    vec_t v;
    v.qlen = ql; v.slen = sl; v.bytes = b; v.exp_q = eq; v.exp_s = es;
    v.exp_drop = ed; v.exp_err = ee; v.contig = ct;
    return v;
  endfunction

  task automatic clear_tracking();
    sb.delete();
    last_q_cyc = -1; first_s_cyc = -1; last_s_cyc = -1;
    s_cnt = 0; done_cyc = -1; done_cnt = 0; ready_seen = 1'b0;
  endtask

  task automatic push_codes(input string s, input logic is_sub);
    byte c;
    for (int k = 0; k < s.len(); k++) begin
      c = s[k];
      sb.push_back({is_sub, 3'(c - 8'd48)});
    end
  endtask

  task automatic pulse_start(input int ql, input int sl);
    start = 1'b1; query_len = 16'(ql); sub_len = 16'(sl);
    @(posedge com_clk); #1;
    start = 1'b0;
  endtask

  // Offer bytes one at a time, advancing only on an accepted handshake.
  task automatic feed(input string b);
    int i = 0;
    int guard = 0;
    bit acc;
    while (i < b.len() && done_cnt == 0 && guard < 200) begin
      in_data = b[i]; in_valid = 1'b1;
      @(negedge com_clk);
      acc = in_ready;
      @(posedge com_clk); #1;
      if (acc) i++;
      guard++;
    end
    in_valid = 1'b0;
    if (guard >= 200) check("byte_feed_timeout", 1, 0);
  endtask

  task automatic wait_done();
    int guard = 0;
    while (done_cnt == 0 && guard < 100) begin
      @(posedge com_clk); #1;
      guard++;
    end
    check("done_seen", done_cnt > 0, 1);
    repeat (3) @(posedge com_clk);
    #1;
  endtask

  task automatic run_vec(input int idx);
    vec_t v = vecs[idx];
    clear_tracking();
    push_codes(v.exp_q, 1'b0);
    push_codes(v.exp_s, 1'b1);
    pulse_start(v.qlen, v.slen);
    feed(v.bytes);
    wait_done();
    check("queue_empty", sb.size(), 0);
    check("done_pulses", done_cnt, 1);
    check("err", err, v.exp_err);
    check("dropped_count", dropped_count, v.exp_drop);
    check("busy_idle", busy, 0);
    if (v.contig) begin
      check("no_bubble_q_to_s", first_s_cyc, last_q_cyc + 1);
      check("sub_contiguous", last_s_cyc - first_s_cyc + 1, s_cnt);
    end
    if (v.exp_s.len() > 0) check("done_after_last_sub", done_cyc, last_s_cyc + 1);
    else check("no_sub_strobe", s_cnt, 0);
    $display("run %0d: qlen=%0d slen=%0d sub_strobes=%0d dropped=%0d err=%0d",
             idx, v.qlen, v.slen, s_cnt, dropped_count, err);
  endtask

  function automatic longint all_outs();
    return longint'({in_ready, query_char_out, query_enable, sub_char_out, sub_enable,
                     busy, done, err, dropped_count});
  endfunction

  initial begin
    vecs[0] = mk(3, 4, "AGTTACG",  "123", "3142000000", 0, 0, 1'b1);
    vecs[1] = mk(3, 1, "a\nG Tc",  "123", "4000000",    2, 0, 1'b1);
    vecs[2] = mk(1, 3, "GANC",     "2",   "104000000",  0, 0, 1'b1);
    vecs[3] = mk(4, 2, "AGN",      "12",  "",           0, 1, 1'b0);
    vecs[4] = mk(2, 0, "CA",       "41",  "000000",     0, 0, 1'b1);
    vecs[5] = mk(2, 2, "t?g!a@c",  "32",  "14000000",   3, 0, 1'b0);

    reset = 1'b1; start = 1'b0; query_len = '0; sub_len = '0;
    in_data = '0; in_valid = 1'b0;
    clear_tracking();
    repeat (3) @(posedge com_clk);
    @(negedge com_clk);
    check("reset_outputs", all_outs(), 0);
    @(posedge com_clk); #1;
    reset = 1'b0;
    @(negedge com_clk);
    check("idle_outputs", all_outs(), 0);
    @(posedge com_clk); #1;

    for (int k = 0; k < 6; k++) run_vec(k);

    // Zero-length query: error and done with no byte ever accepted.
    clear_tracking();
    in_data = 8'h41; in_valid = 1'b1;
    pulse_start(0, 3);
    @(negedge com_clk);
    check("qlen0_c1_done", done, 0);
    check("qlen0_c1_err", err, 1);
    check("qlen0_c1_busy", busy, 1);
    @(posedge com_clk); #1;
    @(negedge com_clk);
    check("qlen0_c2_done", done, 1);
    check("qlen0_c2_busy", busy, 0);
    repeat (4) @(posedge com_clk);
    #1;
    in_valid = 1'b0;
    check("qlen0_ready_never", ready_seen, 0);
    check("qlen0_done_pulses", done_cnt, 1);
    $display("run qlen0: err=%0d done_pulses=%0d", err, done_cnt);

    // Reset in SUB after 2 of 5 subject characters (one byte dropped first).
    clear_tracking();
    push_codes("2", 1'b0);
    push_codes("14", 1'b1);
    pulse_start(1, 5);
    feed("G?AC");
    @(negedge com_clk);
    check("pre_reset_dropped", dropped_count, 1);
    check("pre_reset_busy", busy, 1);
    @(posedge com_clk); #1;
    reset = 1'b1;
    @(posedge com_clk);
    @(negedge com_clk);
    check("midrun_reset_outputs", all_outs(), 0);
    @(posedge com_clk); #1;
    reset = 1'b0;
    repeat (12) @(posedge com_clk);
    #1;
    check("midrun_no_done", done_cnt, 0);
    check("midrun_queue_empty", sb.size(), 0);
    check("midrun_busy", busy, 0);
    $display("run reset-mid-sub: done_pulses=%0d", done_cnt);

    // Clean run after the abandoned one; drop count restarts from zero.
    run_vec(0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_failed);
    $finish;
  end

endmodule
